// File: rtl/shufflenetv2_acc_requant.sv
// Accumulates cfg_len unsigned products per output pixel, then shifts and saturates the sum to an unsigned activation.
// Define SHUFFLENETV2_ROUND_EN to round half up before the shift; by default the shift truncates.
module shufflenetv2_acc_requant #(
  parameter int PROD_WIDTH = 24,
  parameter int LEN_WIDTH  = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [4:0]            cfg_shift,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] in_prod,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sat
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACC = 1'b1} state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ACC_WIDTH:0]   OUT_MAX  = {{(ACC_WIDTH+1-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};
`ifdef SHUFFLENETV2_ROUND_EN
  localparam logic [ACC_WIDTH:0]   ACC_ONE  = {{ACC_WIDTH{1'b0}}, 1'b1};
`endif

  state_t                 state_r;
  logic [LEN_WIDTH-1:0]   cnt_r;
  logic [LEN_WIDTH-1:0]   len_r;
  logic [4:0]             shift_r;
  logic [ACC_WIDTH-1:0]   acc_r;
  logic                   out_valid_r;
  logic [OUT_WIDTH-1:0]   out_data_r;
  logic                   out_sat_r;

  logic                   in_ready_s;
  logic                   accept_s;
  logic                   final_s;
  logic [LEN_WIDTH-1:0]   eff_len_s;
  logic [4:0]             eff_shift_s;
  logic [LEN_WIDTH-1:0]   cnt_next_s;
  logic [ACC_WIDTH-1:0]   prod_ext_s;
  logic [ACC_WIDTH-1:0]   sum_s;
  logic [OUT_WIDTH:0]     quant_s;

  // Shift (optionally rounded) at one extra bit so the sum can never wrap, then clip to the output range.
  function automatic logic [OUT_WIDTH:0] requant(input logic [ACC_WIDTH-1:0] sum,
                                                 input logic [4:0]           sh);
    logic [ACC_WIDTH:0] ext;
    logic [ACC_WIDTH:0] r;
    ext = {1'b0, sum};
`ifdef SHUFFLENETV2_ROUND_EN
    if (sh != 5'd0) begin
      ext = ext + (ACC_ONE << (sh - 5'd1));
    end else begin
      ext = ext;
    end
`endif
    r = ext >> sh;
    if (r > OUT_MAX) begin
      requant = {1'b1, {OUT_WIDTH{1'b1}}};
    end else begin
      requant = {1'b0, r[OUT_WIDTH-1:0]};
    end
  endfunction

  // Handshake, group-length selection and the combinational sum of the beat being accepted.
  always_comb begin
    in_ready_s  = !out_valid_r || out_ready;
    accept_s    = in_valid && in_ready_s;
    prod_ext_s  = {{(ACC_WIDTH-PROD_WIDTH){1'b0}}, in_prod};
    cnt_next_s  = cnt_r + LEN_ONE;
    // The first beat of a group uses the live config; later beats use the latched copy.
    if (state_r == ST_IDLE) begin
      eff_len_s   = (cfg_len == {LEN_WIDTH{1'b0}}) ? LEN_ONE : cfg_len;
      eff_shift_s = cfg_shift;
      sum_s       = prod_ext_s;
    end else begin
      eff_len_s   = len_r;
      eff_shift_s = shift_r;
      sum_s       = acc_r + prod_ext_s;
    end
    final_s = accept_s && (cnt_next_s == eff_len_s);
    quant_s = requant(sum_s, eff_shift_s);
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sat   = out_sat_r;

  // Group state machine plus the result register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {LEN_WIDTH{1'b0}};
      len_r       <= LEN_ONE;
      shift_r     <= 5'd0;
      acc_r       <= {ACC_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_WIDTH{1'b0}};
      out_sat_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        case (state_r)
          ST_IDLE: begin
            len_r   <= eff_len_s;
            shift_r <= cfg_shift;
          end
          ST_ACC: begin
            len_r   <= len_r;
            shift_r <= shift_r;
          end
          default: begin
            len_r   <= LEN_ONE;
            shift_r <= 5'd0;
          end
        endcase
        if (final_s) begin
          state_r <= ST_IDLE;
          cnt_r   <= {LEN_WIDTH{1'b0}};
          acc_r   <= {ACC_WIDTH{1'b0}};
        end else begin
          state_r <= ST_ACC;
          cnt_r   <= cnt_next_s;
          acc_r   <= sum_s;
        end
      end
      // A new final beat wins over a drain in the same cycle.
      if (final_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= quant_s[OUT_WIDTH-1:0];
        out_sat_r   <= quant_s[OUT_WIDTH];
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shufflenetv2_acc_requant.sv
// Directed scoreboard bench for shufflenetv2_acc_requant.
module tb_shufflenetv2_acc_requant;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [7:0]  cfg_len = 8'd1;
  logic [4:0]  cfg_shift = 5'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_prod = 24'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_sat;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int pushed = 0;
  int popped = 0;
  logic [8:0] sb_q[$];

  shufflenetv2_acc_requant dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cfg_len(cfg_len), .cfg_shift(cfg_shift),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_res(input logic [7:0] d, input logic s);
    sb_q.push_back({s, d});
    pushed++;
  endtask

  // Drive one beat and return #1 after the edge that accepted it.
  task automatic beat(input logic [23:0] p);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_prod  = p;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge ap_clk);
      done = in_ready;
      @(posedge ap_clk);
      #1;
    end
    if (!done) chk("beat_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // Monitor: every transfer must match the oldest expected result.
  always @(negedge ap_clk) begin
    if (ap_rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        popped++;
        chk("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
        chk("out_sat", {31'd0, out_sat}, {31'd0, e[8]});
      end
    end
  end

  initial begin
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_sat", {31'd0, out_sat}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // len 3, shift 4: 600 >> 4
    cfg_len = 8'd3; cfg_shift = 5'd4;
    beat(24'd100);
    beat(24'd200);
    chk("len3_not_yet", {31'd0, out_valid}, 32'd0);
`ifdef SHUFFLENETV2_ROUND_EN
    expect_res(8'd38, 1'b0);
`else
    expect_res(8'd37, 1'b0);
`endif
    beat(24'd300);
    chk("len3_latency", {31'd0, out_valid}, 32'd1);

    // len 1 saturation then exact max, back to back
    cfg_len = 8'd1; cfg_shift = 5'd0;
    expect_res(8'd255, 1'b1);
    beat(24'd1000);
    chk("len1_first_valid", {31'd0, out_valid}, 32'd1);
    expect_res(8'd255, 1'b0);
    beat(24'd255);
    chk("len1_b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("len1_b2b_sat", {31'd0, out_sat}, 32'd0);

    // len 0 behaves as 1
    cfg_len = 8'd0;
    expect_res(8'd7, 1'b0);
    beat(24'd7);
    chk("len0_valid", {31'd0, out_valid}, 32'd1);

    // Backpressure with len 2
    cfg_len = 8'd2;
    expect_res(8'd30, 1'b0);
    beat(24'd10);
    beat(24'd20);
    out_ready = 1'b0;
    in_valid = 1'b1; in_prod = 24'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", {24'd0, out_data}, 32'd30);
      @(posedge ap_clk); #1;
    end
    out_ready = 1'b1;
    @(negedge ap_clk);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    chk("release_drained", {31'd0, out_valid}, 32'd0);
    expect_res(8'd7, 1'b0);
    beat(24'd4);
    chk("release_group_done", {31'd0, out_valid}, 32'd1);

    // Mid-group config change is ignored
    cfg_len = 8'd4; cfg_shift = 5'd0;
    beat(24'd1);
    beat(24'd2);
    cfg_len = 8'd2;
    beat(24'd3);
    chk("cfg_change_held", {31'd0, out_valid}, 32'd0);
    expect_res(8'd10, 1'b0);
    beat(24'd4);
    chk("len4_closed", {31'd0, out_valid}, 32'd1);
    expect_res(8'd11, 1'b0);
    beat(24'd5);
    chk("len2_open", {31'd0, out_valid}, 32'd0);
    beat(24'd6);
    chk("len2_closed", {31'd0, out_valid}, 32'd1);

    // Reset mid-group discards the partial sum
    cfg_len = 8'd3; cfg_shift = 5'd4;
    beat(24'd5);
    beat(24'd5);
    ap_rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_data", {24'd0, out_data}, 32'd0);
    chk("midrst_sat", {31'd0, out_sat}, 32'd0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    expect_res(8'd3, 1'b0);
    beat(24'd16);
    beat(24'd16);
    chk("post_rst_open", {31'd0, out_valid}, 32'd0);
    beat(24'd16);
    chk("post_rst_closed", {31'd0, out_valid}, 32'd1);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge ap_clk);
    #1;
    chk("sb_empty", sb_q.size(), 32'd0);
    chk("sb_count", popped, pushed);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
